parity_fifo_top: RTL and testbench
==================================

# parity_fifo_top

Synchronous FIFO with a parity checker on the read side. Each stored word is DATA_WIDTH payload bits plus one parity bit. Words that fail the parity check at the head of the queue are consumed and dropped rather than presented as valid. The block sits between a producer and a consumer, each using a valid/grant handshake.

## Interface
- DATA_WIDTH, 32: payload bits per word; every data port is DATA_WIDTH+1 bits wide.
- FIFO_DEPTH, 4: number of entries; any value ≥2, power of two not required.
- EVEN_ODD, 0: parity sense; 0 = even, 1 = odd.
- PARITY_BIT, 0: parity bit position; 0 = bit 0, 1 = bit DATA_WIDTH.
- clk, input, 1: sole clock, rising edge.
- rst_n, input, 1: reset, synchronous, active-low.
- push_data_i, input, DATA_WIDTH+1: write word, including parity bit.
- push_valid_i, input, 1: producer has a word.
- push_grant_o, output, 1: FIFO can accept a word.
- pop_grant_i, input, 1: consumer takes the head word.
- pop_data_o, output, DATA_WIDTH+1: head word, full word including parity.
- pop_valid_o, output, 1: head word present and parity-correct.

## Operation
- **Write:** occurs at posedge when push_valid_i && push_grant_o. Word goes to memory[count_write]; count_write increments with wrap FIFO_DEPTH-1→0.
- **Read:** occurs at posedge when pop_grant_i && FIFO not empty. count_read increments with the same wrap. The read happens whether the head is parity-correct or corrupt.
- **Occupancy:** count_fifo ranges 0..FIFO_DEPTH.
  - Increments on write only, decrements on read only.
  - Unchanged on simultaneous write and read.
- **Flow control:**
  - push_grant_o = rst_n && (count_fifo != FIFO_DEPTH).
  - When full, a push is refused even if a pop occurs in the same cycle.
  - When empty, a pop is ignored even if a push occurs in the same cycle; there is no bypass.
- **Parity check:**
  - A head word is good when the XOR of all DATA_WIDTH+1 bits equals EVEN_ODD.
  - pop_valid_o = rst_n && not empty && good.
  - Corrupt head: pop_valid_o=0, but a pop_grant_i still discards the word.
- **Head data:** pop_data_o = memory[count_read] when not empty, else all zeros.
- **Overflow/underflow:** impossible by construction; refused pushes and pops leave all state unchanged.

## Timing
- Reset (rst_n low at posedge):
  - count_read, count_write and count_fifo go to 0; memory is not cleared.
  - While rst_n is low, push_grant_o=0 and pop_valid_o=0, and all pushes and pops are ignored.
  - After release, the block is empty: push_grant_o=1, pop_valid_o=0, pop_data_o=0.
- Reset mid-operation discards all contents at that edge.
- Show-ahead read, zero latency:
  - pop_data_o and pop_valid_o are combinational from state.
  - A written word appears at the head in the cycle after the write edge when the FIFO was empty.
- push_grant_o and pop_valid_o change only after a clock edge or a change of rst_n; neither depends combinationally on push_valid_i or pop_grant_i.

## Configuration
- PARITY_CHECK_EN defined: the parity checker behaves as above.
- PARITY_CHECK_EN undefined:
  - Checker removed; pop_valid_o = rst_n && not empty.
  - EVEN_ODD and PARITY_BIT have no effect.
  - Data still passes unmodified.

## Structure
- Package parity_fifo_pkg holds:
  - the word type logic [DATA_WIDTH:0];
  - a parity_ok(word, even_odd) function.
- One sub-module, sync_fifo, instantiated as fifo_i. It contains:
  - storage array my_ram.memory;
  - counters count_read, count_write, count_fifo;
  - its own pop_valid_o, meaning "not empty".
- The top applies the parity gating to sync_fifo's outputs.
- These hierarchical names are fixed; benches reference them.

## Test plan
All scenarios use DATA_WIDTH=32, FIFO_DEPTH=4, EVEN_ODD=0, PARITY_BIT=0, PARITY_CHECK_EN defined.

1. **Reset:** hold rst_n=0 for one edge, then release → all count_* =0; push_grant_o=1; pop_valid_o=0; pop_data_o=0.
2. **Overflow:** push 6 parity-correct words 0x3, 0x5, 0x6, 0x9, 0xA, 0xC → first four accepted; push_grant_o=0 after the 4th; words 5–6 dropped; count_fifo=4.
3. **Underflow:** 6 pops after scenario 2 → 0x3, 0x5, 0x6, 0x9 delivered in order with pop_valid_o=1. Then pop_valid_o=0, count_fifo stays 0, pointers unchanged.
4. **Corrupt word:** push 0x2 then 0x3 →
   - first head: pop_valid_o=0, pop_data_o=0x2;
   - pop_grant_i discards it;
   - next head: 0x3 with pop_valid_o=1.
5. **Simultaneous push and pop:**
   - at count_fifo=2 → count stays 2, data order preserved;
   - at full, push+pop → only the pop is taken;
   - at empty, push+pop → only the push is taken.
6. **Wrap-around:** 30 rounds of 2 pushes and 1 pop, parity-correct data → order is preserved across pointer wrap; push_grant_o drops exactly when count_fifo=4.

Source files
------------

// File: rtl/parity_fifo_pkg.sv
// Shared word type and parity helper for parity_fifo_top and its storage FIFO.
package parity_fifo_pkg;

    localparam int DEFAULT_DATA_WIDTH = 32;

    // Payload plus one parity bit.
    typedef logic [DEFAULT_DATA_WIDTH:0] word_t;

    function automatic logic parity_ok(input word_t word, input logic even_odd);
        return (^word) == even_odd;
    endfunction

endpackage

// File: rtl/sync_fifo.sv
// Plain synchronous show-ahead FIFO with wrapping read/write pointers and an
// occupancy counter; pop_valid_o here only means "not empty".
module sync_fifo
    import parity_fifo_pkg::*;
#(
    parameter int DATA_WIDTH = DEFAULT_DATA_WIDTH,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic [DATA_WIDTH:0] push_data_i,
    input  logic                push_valid_i,
    output logic                push_grant_o,
    input  logic                pop_grant_i,
    output logic [DATA_WIDTH:0] pop_data_o,
    output logic                pop_valid_o
);

    localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int CNT_W = $clog2(FIFO_DEPTH + 1);
    localparam logic [PTR_W-1:0] LAST_PTR = PTR_W'(FIFO_DEPTH - 1);
    localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(FIFO_DEPTH);

    logic [PTR_W-1:0] count_read;
    logic [PTR_W-1:0] count_write;
    logic [CNT_W-1:0] count_fifo;

    logic w_full;
    logic w_empty;
    logic w_wr;
    logic w_rd;

    assign w_full       = (count_fifo == FULL_CNT);
    assign w_empty      = (count_fifo == '0);
    assign push_grant_o = rst_n && !w_full;
    assign pop_valid_o  = rst_n && !w_empty;
    // Both strobes carry rst_n, so nothing moves while reset is held.
    assign w_wr         = push_valid_i && push_grant_o;
    assign w_rd         = pop_grant_i && pop_valid_o;

    if (1) begin : my_ram
        logic [DATA_WIDTH:0] memory [FIFO_DEPTH];

        // NOTE: storage is deliberately not reset; the counters alone define
        // which entries are live, and resetting an array costs a mux per bit.
        always_ff @(posedge clk) begin
            if (w_wr) begin
                memory[count_write] <= push_data_i;
            end
        end
    end

    // NOTE: state registers use non-blocking assignments so every flop samples
    // the pre-edge values, independent of statement order.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            count_read  <= '0;
            count_write <= '0;
            count_fifo  <= '0;
        end else begin
            if (w_wr) begin
                count_write <= (count_write == LAST_PTR) ? '0 : count_write + 1'b1;
            end
            if (w_rd) begin
                count_read <= (count_read == LAST_PTR) ? '0 : count_read + 1'b1;
            end
            case ({w_wr, w_rd})
                2'b10:   count_fifo <= count_fifo + 1'b1;
                2'b01:   count_fifo <= count_fifo - 1'b1;
                default: count_fifo <= count_fifo;
            endcase
        end
    end

    // NOTE: the default assignment first guarantees no latch is inferred.
    always_comb begin
        pop_data_o = '0;
        if (!w_empty) begin
            pop_data_o = my_ram.memory[count_read];
        end
    end

endmodule

// File: rtl/parity_fifo_top.sv
// FIFO whose head word is withheld (but still poppable) when its parity is wrong.
// Build option: define PARITY_CHECK_EN to enable the checker; otherwise data is passed unchecked.
module parity_fifo_top
    import parity_fifo_pkg::*;
#(
    parameter int DATA_WIDTH = DEFAULT_DATA_WIDTH,
    parameter int FIFO_DEPTH = 4,
    parameter int EVEN_ODD   = 0,
    parameter int PARITY_BIT = 0
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic [DATA_WIDTH:0] push_data_i,
    input  logic                push_valid_i,
    output logic                push_grant_o,
    input  logic                pop_grant_i,
    output logic [DATA_WIDTH:0] pop_data_o,
    output logic                pop_valid_o
);

    logic [DATA_WIDTH:0] w_head;
    logic                w_fifo_valid;

    // The FIFO pops on its own "not empty", so corrupt heads are discarded too.
    sync_fifo #(
        .DATA_WIDTH (DATA_WIDTH),
        .FIFO_DEPTH (FIFO_DEPTH)
    ) fifo_i (
        .clk          (clk),
        .rst_n        (rst_n),
        .push_data_i  (push_data_i),
        .push_valid_i (push_valid_i),
        .push_grant_o (push_grant_o),
        .pop_grant_i  (pop_grant_i),
        .pop_data_o   (w_head),
        .pop_valid_o  (w_fifo_valid)
    );

    assign pop_data_o = w_head;

`ifdef PARITY_CHECK_EN
    word_t w_check;
    logic  w_good;
    logic  w_unused_cfg;

    if (DATA_WIDTH == DEFAULT_DATA_WIDTH) begin : g_direct
        assign w_check = w_head;
    end else begin : g_fold
        // Only the XOR of the whole word matters, so reduce it to one bit first.
        assign w_check = word_t'(^w_head);
    end

    assign w_good       = parity_ok(w_check, 1'(EVEN_ODD));
    assign pop_valid_o  = w_fifo_valid && w_good;
    // The check covers every bit, so the parity bit's position never matters.
    assign w_unused_cfg = 1'(PARITY_BIT);
`else
    logic w_unused_cfg;

    assign pop_valid_o  = w_fifo_valid;
    assign w_unused_cfg = ^{1'(EVEN_ODD), 1'(PARITY_BIT)};
`endif

endmodule

// File: tb/tb_parity_fifo_top.sv
// Randomized self-checking bench for parity_fifo_top against a queue-based model.
module tb_parity_fifo_top;

    localparam int DW    = 32;
    localparam int DEPTH = 4;

    typedef logic [DW:0] word_t;

    logic  clk = 1'b0;
    logic  rst_n;
    word_t push_data_i;
    logic  push_valid_i;
    logic  push_grant_o;
    logic  pop_grant_i;
    word_t pop_data_o;
    logic  pop_valid_o;

    parity_fifo_top #(
        .DATA_WIDTH (DW),
        .FIFO_DEPTH (DEPTH),
        .EVEN_ODD   (0),
        .PARITY_BIT (0)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .push_data_i  (push_data_i),
        .push_valid_i (push_valid_i),
        .push_grant_o (push_grant_o),
        .pop_grant_i  (pop_grant_i),
        .pop_data_o   (pop_data_o),
        .pop_valid_o  (pop_valid_o)
    );

    always #5 clk = ~clk;

    int    n_checks = 0;
    int    n_bad    = 0;
    word_t model_q[$];
    int    wr_total = 0;
    int    rd_total = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got=0x%0h expected=0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Even parity over all 33 bits, unless the checker is compiled out.
    function automatic logic word_good(input word_t w);
`ifdef PARITY_CHECK_EN
        return (^w) == 1'b0;
`else
        return 1'b1;
`endif
    endfunction

    function automatic word_t mk_word(input logic [31:0] v, input logic corrupt);
        word_t w;
        w[DW:1] = v;
        w[0]    = (^v) ^ corrupt;
        return w;
    endfunction

    task automatic check_outputs();
        int    n;
        word_t head;
        n    = model_q.size();
        head = (n != 0) ? model_q[0] : '0;
        check("push_grant", 64'(push_grant_o), 64'(rst_n && n != DEPTH));
        check("pop_valid",  64'(pop_valid_o),  64'(rst_n && n != 0 && word_good(head)));
        check("pop_data",   64'(pop_data_o),   64'(head));
        check("count_fifo", 64'(dut.fifo_i.count_fifo),  64'(n));
        check("count_read", 64'(dut.fifo_i.count_read),  64'(rd_total % DEPTH));
        check("count_write",64'(dut.fifo_i.count_write), 64'(wr_total % DEPTH));
    endtask

    // One clock: drive inputs, check the current state, predict the edge.
    task automatic cycle(input logic rst, input logic pv, input word_t d, input logic pg);
        @(negedge clk);
        rst_n        = rst;
        push_valid_i = pv;
        push_data_i  = d;
        pop_grant_i  = pg;
        #1;
        check_outputs();
        if (!rst) begin
            model_q.delete();
            wr_total = 0;
            rd_total = 0;
        end else begin
            logic do_push;
            logic do_pop;
            do_push = pv && (model_q.size() < DEPTH);
            do_pop  = pg && (model_q.size() > 0);
            if (do_pop) begin
                void'(model_q.pop_front());
                rd_total++;
            end
            if (do_push) begin
                model_q.push_back(d);
                wr_total++;
            end
        end
        @(posedge clk);
    endtask

    task automatic push(input word_t d);
        cycle(1'b1, 1'b1, d, 1'b0);
    endtask

    task automatic pop();
        cycle(1'b1, 1'b0, '0, 1'b1);
    endtask

    task automatic push_pop(input word_t d);
        cycle(1'b1, 1'b1, d, 1'b1);
    endtask

    initial begin
        rst_n        = 1'b0;
        push_valid_i = 1'b0;
        push_data_i  = '0;
        pop_grant_i  = 1'b0;
        repeat (2) @(posedge clk);

        // Reset: one edge low while offering a push and a pop, then release.
        cycle(1'b0, 1'b1, 33'h3, 1'b1);
        cycle(1'b1, 1'b0, '0, 1'b0);

        // Overflow then underflow.
        push(33'h3); push(33'h5); push(33'h6); push(33'h9); push(33'hA); push(33'hC);
        repeat (6) pop();
        cycle(1'b1, 1'b0, '0, 1'b0);

        // Corrupt head is withheld but still discarded by a pop.
        push(33'h2); push(33'h3);
        pop(); pop();
        cycle(1'b1, 1'b0, '0, 1'b0);

        // Simultaneous push and pop at mid, full and empty occupancy.
        push(33'h11); push(33'h22);
        push_pop(33'h33);
        push(33'h44); push(33'h55);
        push_pop(33'h66);
        repeat (4) pop();
        push_pop(33'h77);
        pop();
        cycle(1'b1, 1'b0, '0, 1'b0);

        // Pointer wrap-around under sustained pressure.
        for (int r = 0; r < 30; r++) begin
            push(mk_word($urandom, 1'b0));
            push(mk_word($urandom, 1'b0));
            pop();
        end
        repeat (DEPTH + 1) pop();

        // Random traffic with corrupt words and occasional mid-stream reset.
        for (int i = 0; i < 400; i++) begin
            logic rst;
            logic pv;
            logic pg;
            rst = ($urandom_range(0, 39) != 0);
            pv  = ($urandom_range(0, 9) < 7);
            pg  = ($urandom_range(0, 1) == 1);
            cycle(rst, pv, mk_word($urandom, $urandom_range(0, 4) == 0), pg);
        end
        repeat (DEPTH + 1) pop();
        cycle(1'b1, 1'b0, '0, 1'b0);

        $display("test done: total=%0d bad=%0d", n_checks, n_bad);
        $finish;
    end

endmodule
